// File: rtl/machine_timer_pkg.sv
// Shared register map, CTRL bit index and reset default for the machine timer.
package machine_timer_pkg;

  localparam logic [4:0] OffMtimeLo    = 5'h00;
  localparam logic [4:0] OffMtimeHi    = 5'h04;
  localparam logic [4:0] OffMtimecmpLo = 5'h08;
  localparam logic [4:0] OffMtimecmpHi = 5'h0C;
  localparam logic [4:0] OffCtrl       = 5'h10;
  localparam logic [4:0] OffPrescale   = 5'h14;

  localparam int unsigned CtrlEnBit = 0;

  localparam logic [63:0] MtimecmpRst = 64'hFFFF_FFFF_FFFF_FFFF;

  // Byte offsets are word aligned; the low two address bits never select anything.
  function automatic logic [4:0] word_align(input logic [4:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/mtime_counter.sv
// 64-bit mtime counter with per-word write and optional prescaler
// (prescaler present only when MACHINE_TIMER_PRESCALE_EN is defined).
module mtime_counter
`ifdef MACHINE_TIMER_PRESCALE_EN
#(
  parameter int unsigned PrescaleW = 16
)
`endif
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic [31:0]          wdata_i,
`ifdef MACHINE_TIMER_PRESCALE_EN
  input  logic                 prescale_wr_i,
  input  logic [PrescaleW-1:0] prescale_i,
`endif
  output logic [63:0]          mtime_o
);

  logic        tick;
  logic        inc;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

`ifdef MACHINE_TIMER_PRESCALE_EN
  logic [PrescaleW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    tick   = 1'b0;
    if (prescale_wr_i) begin
      pcnt_d = '0;
    end else if (en_i) begin
      if (pcnt_q == prescale_i) begin
        tick   = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end
`else
  assign tick = en_i;
`endif

  // Any word write freezes the whole counter for that cycle, so no carry crosses words.
  assign inc = tick & ~wr_lo_i & ~wr_hi_i;

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (wr_lo_i)  lo_d = wdata_i;
    else if (inc) lo_d = lo_q + 32'd1;
    if (wr_hi_i)               hi_d = wdata_i;
    else if (inc && (&lo_q))   hi_d = hi_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign mtime_o = {hi_q, lo_q};

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V machine timer: bus decode, LO/HI snapshot and compare interrupt.
// Build option: MACHINE_TIMER_PRESCALE_EN adds a programmable tick prescaler.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [63:0] CMP_RST    = MtimecmpRst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        timer_interrupt
);

  logic [4:0]  off;
  logic        rd_req, wr_req;
  logic        wr_lo, wr_hi;
  logic [63:0] mtime;

  logic        en_q, en_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        unused_addr;

  assign off         = word_align(addr);
  assign rd_req      = req & ~we;
  assign wr_req      = req & we;
  assign wr_lo       = wr_req && (off == OffMtimeLo);
  assign wr_hi       = wr_req && (off == OffMtimeHi);
  assign unused_addr = ^addr[1:0];

`ifdef MACHINE_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  wr_prescale;

  assign wr_prescale = wr_req && (off == OffPrescale);
  assign prescale_d  = wr_prescale ? wdata[PRESCALE_W-1:0] : prescale_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prescale_q <= '0;
    else      prescale_q <= prescale_d;
  end

  mtime_counter #(
    .PrescaleW (PRESCALE_W)
  ) u_counter (
    .clk_i         (clk),
    .rst_ni        (rst),
    .en_i          (en_q),
    .wr_lo_i       (wr_lo),
    .wr_hi_i       (wr_hi),
    .wdata_i       (wdata),
    .prescale_wr_i (wr_prescale),
    .prescale_i    (prescale_q),
    .mtime_o       (mtime)
  );
`else
  logic [31:0] unused_prescale_w;
  assign unused_prescale_w = 32'(PRESCALE_W);

  mtime_counter u_counter (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (en_q),
    .wr_lo_i (wr_lo),
    .wr_hi_i (wr_hi),
    .wdata_i (wdata),
    .mtime_o (mtime)
  );
`endif

  always_comb begin
    rdata_d  = '0;
    shadow_d = shadow_q;
    if (rd_req) begin
      case (off)
        OffMtimeLo: begin
          rdata_d  = mtime[31:0];
          shadow_d = mtime[63:32];
        end
        OffMtimeHi:    rdata_d = shadow_q;
        OffMtimecmpLo: rdata_d = cmp_q[31:0];
        OffMtimecmpHi: rdata_d = cmp_q[63:32];
        OffCtrl:       rdata_d[CtrlEnBit] = en_q;
`ifdef MACHINE_TIMER_PRESCALE_EN
        OffPrescale:   rdata_d[PRESCALE_W-1:0] = prescale_q;
`endif
        default:       rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    en_d  = en_q;
    cmp_d = cmp_q;
    if (wr_req) begin
      case (off)
        OffMtimecmpLo: cmp_d[31:0]  = wdata;
        OffMtimecmpHi: cmp_d[63:32] = wdata;
        OffCtrl:       en_d         = wdata[CtrlEnBit];
        default:       ;
      endcase
    end
  end

  assign irq_d = en_q && (mtime >= cmp_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      cmp_q    <= CMP_RST;
      shadow_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      ack_q    <= req;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign ack             = ack_q;
  assign rdata           = rdata_q;
  assign timer_interrupt = irq_q;

endmodule

// File: doc/machine_timer.md
MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE_W, default 16: width of the prescale register.
REQ-002 The block SHALL have parameter CMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-005 The block SHALL have port req, input, 1: register access request.
REQ-006 The block SHALL have port we, input, 1: 1 = write, 0 = read; qualified by req.
REQ-007 The block SHALL have port addr, input, 5: byte address; bits [4:2] select the word, bits [1:0] are ignored.
REQ-008 The block SHALL have port wdata, input, 32: write data.
REQ-009 The block SHALL have port ack, output, 1: access-complete strobe.
REQ-010 The block SHALL have port rdata, output, 32: read data, valid only while ack=1.
REQ-011 The block SHALL have port timer_interrupt, output, 1: level interrupt to the CSR block (mip.MTIP source).

Function
REQ-012 The register map SHALL be: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN), 0x14 PRESCALE; all other offsets are unmapped.
REQ-013 Handshake: a request sampled with req=1 SHALL produce ack=1 for exactly one cycle on the next cycle; back-to-back requests SHALL each be acked one cycle later (throughput 1/cycle).
REQ-014 Write data SHALL take effect on the edge that samples the request; rdata SHALL reflect the register state at that same edge.
REQ-015 Unmapped reads SHALL return 32'd0; unmapped writes SHALL be acked and ignored.
REQ-016 Counter: while CTRL.EN=1, the 64-bit mtime SHALL increment by 1 on each tick; while EN=0 it SHALL hold.
REQ-017 mtime SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no side effect.
REQ-018 A write to MTIME_LO or MTIME_HI SHALL replace that word only; in the same cycle it SHALL take priority over the increment, and carry from the other word SHALL be suppressed.
REQ-019 Snapshot: a read of MTIME_LO SHALL capture mtime[63:32] into a shadow register in the same cycle; a read of MTIME_HI SHALL return that shadow, giving a coherent 64-bit read (LO then HI).
REQ-020 The shadow SHALL hold until the next MTIME_LO read; its value after reset SHALL be 0.
REQ-021 timer_interrupt SHALL be registered: next cycle value = EN && (mtime >= mtimecmp), compared unsigned, giving one cycle of latency after any state change.
REQ-022 Writing MTIMECMP above mtime SHALL deassert timer_interrupt on the cycle after the write edge.
REQ-023 CTRL bits [31:1] SHALL read 0 and ignore writes.

Reset
REQ-024 While rst=0, and immediately on assertion, the block SHALL set: mtime=0, mtimecmp=CMP_RST, CTRL.EN=0, PRESCALE=0, prescale counter=0, shadow=0, ack=0, rdata=0, timer_interrupt=0.
REQ-025 A request in flight at reset assertion SHALL be dropped, with no ack after release.

Configuration
REQ-026 The macro SHALL be MACHINE_TIMER_PRESCALE_EN.
REQ-027 When defined: a PRESCALE_W-bit counter SHALL count 0..PRESCALE while EN=1 and produce a tick on reaching PRESCALE, then restart at 0; PRESCALE=0 SHALL give a tick every cycle; writing PRESCALE SHALL restart the counter at 0; EN=0 SHALL hold the counter.
REQ-028 When not defined: a tick SHALL occur every cycle while EN=1; PRESCALE SHALL read 0 and ignore writes; no prescale counter SHALL be present.

Structure
REQ-029 Package machine_timer_pkg SHALL hold the register offset localparams, the CTRL bit index and the reset default of mtimecmp.
REQ-030 The 64-bit counter with prescaler SHALL be a sub-module mtime_counter (inputs: tick enable, word write strobes/data; output: mtime); the bus decode and compare logic SHALL stay in machine_timer.

Verification
REQ-031 Reset release, write CTRL=1, wait 10 cycles, read MTIME_LO -> rdata in the expected window around 10; timer_interrupt=0 (mtimecmp=all ones).
REQ-032 Write MTIMECMP_HI=0 and MTIMECMP_LO=20 with EN=1 -> timer_interrupt rises on the cycle after mtime reaches 20; then write MTIMECMP_LO=0xFFFF_FFFF -> it falls one cycle after the write.
REQ-033 Write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE with EN=1; after it wraps to MTIME_HI=1, read LO then HI -> HI=1 and the {HI,LO} pair is coherent; at a forced 64-bit all-ones value mtime wraps to 0.
REQ-034 With the macro defined, PRESCALE=3 and EN=1 for 40 cycles -> mtime advanced by 10; without the macro, a PRESCALE read returns 0.
REQ-035 Back-to-back reads to 0x10, 0x18 (unmapped) and 0x14 -> three consecutive ack pulses; rdata = 1, 0 and the PRESCALE value respectively.
REQ-036 Drive rst=0 mid-count with a pending req -> all outputs are 0 immediately, no ack after release, and mtime=0.
